clock_enable_gen: RTL

//  Parametrised successor to the free-running simulation clock. Runs on the single

---
 rtl/clock_enable_gen_if.sv | 29 ++
 rtl/clock_enable_gen.sv | 113 +++++++++++
 2 files changed

// File: rtl/clock_enable_gen_if.sv
// Control/status bundle between a clock-enable generator and its controller.
// The master drives mode and run controls; the slave returns the CE stream and debug status.
interface clock_enable_gen_if #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned BURST_W = 16,
  parameter int unsigned CNT_W   = 32
);
  logic [1:0]         Mode;
  logic [DIV_W-1:0]   Divisor;
  logic               Go;
  logic [BURST_W-1:0] BurstLen;
  logic               Brk;
  logic               CE;
  logic               Busy;
  logic               Done;
  logic               BrkHit;
  logic [BURST_W-1:0] Remaining;
  logic [CNT_W-1:0]   CycleCount;

  modport master (
    output Mode, Divisor, Go, BurstLen, Brk,
    input  CE, Busy, Done, BrkHit, Remaining, CycleCount
  );

  modport slave (
    input  Mode, Divisor, Go, BurstLen, Brk,
    output CE, Busy, Done, BrkHit, Remaining, CycleCount
  );
endinterface

// File: rtl/clock_enable_gen.sv
// Programmable clock-enable pulse generator: halt, free-run, N-pulse burst and single-step,
// with breakpoint stop and a wrapping CE pulse counter.
module clock_enable_gen #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned BURST_W = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  clock_enable_gen_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_STEP  = 2'b11;

  logic [1:0]         state_q,     state_d;
  logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
  logic               ce_q,        ce_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic               brk_hit_q,   brk_hit_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0]   cycle_q,     cycle_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    ce_d        = 1'b0;
    done_d      = 1'b0;
    brk_hit_d   = brk_hit_q;
    remaining_d = remaining_q;
    cycle_d     = cycle_q;

    if (state_q == ST_RUN || state_q == ST_BURST) begin
      if (bus.Mode == MODE_HALT) begin
        state_d = ST_IDLE;
      end else if (bus.Brk) begin
        // Breakpoint wins over a pending fire: the CE for this edge is swallowed
        state_d   = ST_IDLE;
        brk_hit_d = 1'b1;
      end else if (state_q == ST_RUN && bus.Mode != MODE_RUN) begin
        state_d = ST_IDLE;
      end else if (div_cnt_q >= bus.Divisor) begin
        div_cnt_d = '0;
        ce_d      = 1'b1;
        cycle_d   = cycle_q + CNT_W'(1);
        if (state_q == ST_BURST && remaining_q != '0) begin
          remaining_d = remaining_q - BURST_W'(1);
          if (remaining_q == BURST_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end else if (!bus.Brk) begin
      if (bus.Mode == MODE_RUN) begin
        state_d   = ST_RUN;
        div_cnt_d = '0;
      end else if (bus.Go && bus.Mode == MODE_BURST && bus.BurstLen != '0) begin
        state_d     = ST_BURST;
        div_cnt_d   = '0;
        remaining_d = bus.BurstLen;
        brk_hit_d   = 1'b0;
      end else if (bus.Go && bus.Mode == MODE_STEP) begin
        state_d     = ST_BURST;
        div_cnt_d   = '0;
        remaining_d = BURST_W'(1);
        brk_hit_d   = 1'b0;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      ce_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      brk_hit_q   <= 1'b0;
      remaining_q <= '0;
      cycle_q     <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      ce_q        <= ce_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      brk_hit_q   <= brk_hit_d;
      remaining_q <= remaining_d;
      cycle_q     <= cycle_d;
    end
  end

  assign bus.CE         = ce_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.BrkHit     = brk_hit_q;
  assign bus.Remaining  = remaining_q;
  assign bus.CycleCount = cycle_q;

endmodule
